aes_subkey_fetch: RTL
=====================

# aes_subkey_fetch

Requester-side companion to the AES key schedule. It drives the key schedule's one-hot `subkey_req` handshake, tracks the returned `subkey_idx`, and captures every round key into a local 15-entry store. The cipher datapath can then read round keys in any order: forward for encryption, reverse for decryption. It sits between the key schedule and the round controller, so each new key is expanded only once.

## Interface
Parameters:
- none. Store depth is fixed at 15 × 128 bits, enough for AES-256.

Ports:
- Clock and reset: one clock, `clk`; `rst` is synchronous and active-high.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle request to expand the current key. Sampled only in IDLE or DONE.
- `aes_len`  in  2  key length: 01 = 128, 10 = 192, 11 = 256. Latched on an accepted `start`.
- `ks_rst`  out  1  drives the key schedule's `rst`, which loads the key into it.
- `subkey_req`  out  16  one-hot request to the key schedule.
- `subkey_idx`  in  16  one-hot index from the key schedule.
- `subkey`  in  128  round key from the key schedule, combinational with `subkey_idx`.
- `busy`  out  1  high in LOAD and FETCH.
- `done`  out  1  one-cycle pulse when the store is complete.
- `key_valid`  out  1  high while the store holds a complete key set.
- `err`  out  1  one-cycle pulse when a `start` is rejected.
- `rd_idx`  in  4  round-key read address.
- `rd_key`  out  128  registered round key.

## Operation
Number of round keys, NK, from the latched `aes_len`:
- 01 → NK = 11
- 10 → NK = 13
- 11 → NK = 15

State machine, states IDLE, LOAD, FETCH, DONE:
- **IDLE, start accepted:** on `start` with `aes_len` ≠ 00, latch `aes_len`, clear `key_valid`, clear counter `cnt` to 0, and go to LOAD.
- **IDLE, start rejected:** on `start` with `aes_len` = 00, pulse `err` and stay in IDLE.
- **LOAD:** exactly one cycle.
  - `ks_rst` = 1 (registered output, high only in this state).
  - `subkey_req` = 0.
  - Next state is FETCH.
- **FETCH:**
  - `subkey_req` = 1 << `cnt`.
  - Capture happens when `subkey_req & subkey_idx` ≠ 0: write `subkey` into slot `cnt`, then increment `cnt`.
  - A non-matching cycle is a stall: no write, request held. There is no timeout.
  - The capture with `cnt` = NK−1 moves the FSM to DONE and pulses `done` with `key_valid` = 1 on the next cycle.
- **DONE:**
  - `subkey_req` = 0, so the key schedule does not advance.
  - A `start` with valid `aes_len` behaves as in IDLE and re-expands the key.
  - A `start` with `aes_len` = 00 pulses `err` and keeps the existing store valid.
- `start` during LOAD or FETCH is ignored. No `err` is raised.
- The key schedule's `inv` is tied to 0 at the top level. This block always fetches forward; decryption order is handled by `rd_idx`.
- **Read port:** `rd_key` ← store[`rd_idx`] when `key_valid` and `rd_idx` < NK, otherwise 0.
  - A read of a slot is legal in the same cycle as its capture.
- **Reset mid-operation:** the FSM returns to IDLE and `key_valid`, `done`, `busy`, `ks_rst` and `err` clear. Store contents are not cleared; `rd_key` is gated to 0 by `key_valid`.

## Timing
- Reset values:
  - `ks_rst` 0, `subkey_req` 0, `busy` 0, `done` 0, `key_valid` 0, `err` 0, `rd_key` 0.
  - State IDLE, `cnt` 0.
- `start` at cycle T, with the key schedule always matching:
  - LOAD at T+1.
  - FETCH for cycles T+2 … T+1+NK.
  - `done` at T+2+NK.
- Total latency from `start` to `done`: 13 / 15 / 17 cycles for 128 / 192 / 256-bit keys.
- Every stall cycle in FETCH adds one cycle to this latency.
- `busy` is high from T+1 through T+1+NK.
- `rd_key` latency is 1 cycle from `rd_idx`.
- `err` is registered and appears 1 cycle after the offending `start`.

## Test plan
- **AES-128:** key 000102030405060708090a0b0c0d0e0f, `start` → `done` 13 cycles later. `rd_idx` = 0 returns 000102030405060708090a0b0c0d0e0f; `rd_idx` = 10 returns 13111d7fe3944a17f307a78b4d2b30c5.
- **AES-192:** key 000102…1617 → `done` after 15 cycles. Slot 12 = a4970a331a78dc09c418c271e3a41d5d; `rd_idx` = 13 returns 0.
- **AES-256:** key 000102…1e1f → `done` after 17 cycles. Slot 14 = 24fc79ccbf0979e9371ac23c6d68de36. Reading slots 14 down to 0 returns the FIPS-197 C.3 round keys in reverse.
- **Stall:** a bench model withholds `subkey_idx` matches for 3 cycles at `cnt` = 4. Required: `subkey_req` holds 0x0010, slot 4 is still correct, and `done` arrives 3 cycles late.
- **Rejected starts:** `start` with `aes_len` = 00 in IDLE → `err` pulse, state unchanged. `start` during FETCH → ignored, completes normally.
- **Reset mid-operation:** `rst` at `cnt` = 6 → `busy` = 0 and `key_valid` = 0 next cycle, `rd_key` = 0 for every `rd_idx`. A new `start` completes correctly afterwards.

Source files
------------

// File: rtl/aes_subkey_fetch.sv
// aes_subkey_fetch: drives the key schedule's one-hot request handshake and
// captures every round key into a local 15 x 128 store, so the datapath can
// read round keys in any order after a single expansion.
module aes_subkey_fetch (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   aes_len,
  output logic         ks_rst,
  output logic [15:0]  subkey_req,
  input  logic [15:0]  subkey_idx,
  input  logic [127:0] subkey,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  output logic         err,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [1:0]     len_q, len_d;
  logic           ks_rst_q, ks_rst_d;
  logic           done_q, done_d;
  logic           key_valid_q, key_valid_d;
  logic           err_q, err_d;
  logic [127:0]   rd_key_q, rd_key_d;
  logic           wr_en;
  logic [127:0]   store_q [15];

  // Round-key count for a key length; 00 never reaches the store.
  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      2'b01:   nk_of = 4'd11;
      2'b10:   nk_of = 4'd13;
      2'b11:   nk_of = 4'd15;
      default: nk_of = 4'd0;
    endcase
  endfunction

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      len_q       <= 2'b00;
      ks_rst_q    <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rd_key_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ks_rst_q    <= ks_rst_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      rd_key_q    <= rd_key_d;
    end
  end

  // Key store: not cleared by reset; reads are gated by key_valid instead.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) store_q[cnt_q] <= subkey;
  end

  // Next-state logic. The request is one-hot at cnt, so a match is just
  // the index bit at cnt.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    key_valid_d = key_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (aes_len != 2'b00) begin
            len_d       = aes_len;
            key_valid_d = 1'b0;
            cnt_d       = 4'd0;
            state_d     = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: state_d = S_FETCH;
      S_FETCH: begin
        if (subkey_idx[cnt_q]) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == nk_of(len_q) - 4'd1) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            key_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: request/busy decode from state; ks_rst and read data registered.
  // A read of the slot being captured this cycle forwards the incoming key.
  always_comb begin
    subkey_req = (state_q == S_FETCH) ? (16'h0001 << cnt_q) : 16'h0000;
    busy       = (state_q == S_LOAD) || (state_q == S_FETCH);
    ks_rst_d   = (state_d == S_LOAD);
    rd_key_d   = '0;
    if (key_valid_d && rd_idx < nk_of(len_d))
      rd_key_d = (wr_en && rd_idx == cnt_q) ? subkey : store_q[rd_idx];
  end

  assign ks_rst    = ks_rst_q;
  assign done      = done_q;
  assign key_valid = key_valid_q;
  assign err       = err_q;
  assign rd_key    = rd_key_q;

endmodule
